// File: rtl/opnd_bus_arbiter_24b.sv
// Sticky, burst-capped 2:1 arbiter for a shared 24-bit operand bus, feeding a
// single registered output stage with a valid/ready handshake toward the consumer.
module opnd_bus_arbiter_24b #(
    parameter int WIDTH = 24,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);
    localparam int            CW      = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last;
    logic [CW-1:0] cnt;
    logic          can_accept;
    logic          grant;

    assign can_accept = (state == IDLE) || out_ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the ifs leaves it unassigned and a latch is never inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && can_accept) begin
            if (req0 && req1) begin
                // The current owner keeps the bus until its run reaches the cap.
                gnt1 = (cnt < CNT_MAX) ? last : ~last;
                gnt0 = ~gnt1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign sel       = gnt1;
    assign grant     = gnt0 | gnt1;
    assign out_valid = (state == FULL);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = FULL;
            FULL:    if (!grant && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state    <= IDLE;
            out_data <= '0;
            out_src  <= 1'b0;
            last     <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                out_data <= sel ? data1 : data0;
                out_src  <= gnt1;
                if (gnt1 == last) begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                end else begin
                    last <= gnt1;
                    cnt  <= CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_opnd_bus_arbiter_24b.sv
// Bench for opnd_bus_arbiter_24b: directed scenarios on a BURST=4 instance plus a
// randomized run on BURST=4/1/15 instances against a grant-history reference model.
module tb_opnd_bus_arbiter_24b;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_v[3];
    logic        req1_v[3];
    logic [23:0] data0_v[3];
    logic [23:0] data1_v[3];
    logic        out_ready_v[3];
    logic        gnt0_v[3];
    logic        gnt1_v[3];
    logic        sel_v[3];
    logic        out_valid_v[3];
    logic [23:0] out_data_v[3];
    logic        out_src_v[3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int B = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
        opnd_bus_arbiter_24b #(.WIDTH(24), .BURST(B)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req0_v[g]),
            .data0     (data0_v[g]),
            .gnt0      (gnt0_v[g]),
            .req1      (req1_v[g]),
            .data1     (data1_v[g]),
            .gnt1      (gnt1_v[g]),
            .sel       (sel_v[g]),
            .out_valid (out_valid_v[g]),
            .out_data  (out_data_v[g]),
            .out_src   (out_src_v[g]),
            .out_ready (out_ready_v[g])
        );
    end

    function automatic int burst_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 15);
    endfunction

    // Holds reset over two edges with all inputs idle; returns just after an edge.
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_v[i] = 1'b0;  req1_v[i] = 1'b0;
            data0_v[i] = '0;   data1_v[i] = '0;
            out_ready_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        req0_v[0] = 1'b1; req1_v[0] = 1'b1; data0_v[0] = 24'h123456; out_ready_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0_v[0], gnt1_v[0], sel_v[0]} !== 3'b000) begin
            errors++; $display("FAIL reset_gnts got %b exp 000", {gnt0_v[0], gnt1_v[0], sel_v[0]});
        end
        checks++;
        if ({out_valid_v[0], out_src_v[0], out_data_v[0]} !== 26'h0) begin
            errors++; $display("FAIL reset_out got v=%b s=%b d=%h exp all 0",
                               out_valid_v[0], out_src_v[0], out_data_v[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0; req0_v[0] = 1'b0; req1_v[0] = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0_v[0] = 1'b1; data0_v[0] = 24'hABCDEF; out_ready_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0_v[0], gnt1_v[0], sel_v[0]} !== 3'b100) begin
            errors++; $display("FAIL single_gnt got %b exp 100", {gnt0_v[0], gnt1_v[0], sel_v[0]});
        end
        @(posedge clk); #1 req0_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_v[0] !== 1'b1 || out_data_v[0] !== 24'hABCDEF || out_src_v[0] !== 1'b0) begin
            errors++; $display("FAIL single_out got v=%b d=%h s=%b exp v=1 d=abcdef s=0",
                               out_valid_v[0], out_data_v[0], out_src_v[0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid_v[0] !== 1'b0 || out_data_v[0] !== 24'hABCDEF) begin
            errors++; $display("FAIL single_drain got v=%b d=%h exp v=0 d=abcdef",
                               out_valid_v[0], out_data_v[0]);
        end
    endtask

    task automatic test_burst();
        int          n0 = 0;
        int          n1 = 0;
        bit          prev_src = 1'b0;
        logic [23:0] prev_data = '0;
        bit          exp_src;
        do_reset();
        req0_v[0] = 1'b1; req1_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            data0_v[0] = 24'hA00000 + 24'(n0);
            data1_v[0] = 24'hB00000 + 24'(n1);
            exp_src = ((k / 4) % 2) == 1;
            @(negedge clk);
            checks++;
            if (gnt0_v[0] !== !exp_src || gnt1_v[0] !== exp_src || sel_v[0] !== exp_src) begin
                errors++; $display("FAIL burst_gnt beat %0d got g0=%b g1=%b sel=%b exp g1=%b",
                                   k, gnt0_v[0], gnt1_v[0], sel_v[0], exp_src);
            end
            if (k > 0) begin
                checks++;
                if (out_src_v[0] !== prev_src || out_data_v[0] !== prev_data) begin
                    errors++; $display("FAIL burst_out beat %0d got s=%b d=%h exp s=%b d=%h",
                                       k, out_src_v[0], out_data_v[0], prev_src, prev_data);
                end
            end
            prev_src  = exp_src;
            prev_data = exp_src ? data1_v[0] : data0_v[0];
            if (exp_src) n1++; else n0++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        do_reset();
        req0_v[0] = 1'b1; data0_v[0] = 24'h00A0A0; out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        data0_v[0] = 24'h00B0B0; out_ready_v[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (gnt0_v[0] !== 1'b0 || gnt1_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1 ||
                out_data_v[0] !== 24'h00A0A0) begin
                errors++; $display("FAIL stall cyc %0d got g0=%b g1=%b v=%b d=%h exp 0 0 1 00a0a0",
                                   k, gnt0_v[0], gnt1_v[0], out_valid_v[0], out_data_v[0]);
            end
            @(posedge clk); #1;
        end
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt0_v[0] !== 1'b1) begin
            errors++; $display("FAIL stall_release_gnt got %b exp 1", gnt0_v[0]);
        end
        @(posedge clk); #1 req0_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid_v[0] !== 1'b1 || out_data_v[0] !== 24'h00B0B0) begin
            errors++; $display("FAIL stall_refill got v=%b d=%h exp v=1 d=00b0b0",
                               out_valid_v[0], out_data_v[0]);
        end
    endtask

    task automatic test_saturate();
        bit exp_seq[3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        req0_v[0] = 1'b1; data0_v[0] = 24'h000111; out_ready_v[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (gnt0_v[0] !== 1'b1) begin
                errors++; $display("FAIL sat_lone beat %0d got %b exp 1", k, gnt0_v[0]);
            end
            @(posedge clk); #1;
        end
        req1_v[0] = 1'b1; data1_v[0] = 24'h000222;
        @(negedge clk);
        checks++;
        if ({gnt0_v[0], gnt1_v[0]} !== 2'b01) begin
            errors++; $display("FAIL sat_handover got %b exp 01", {gnt0_v[0], gnt1_v[0]});
        end
        do_reset();
        req0_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        req1_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (gnt1_v[0] !== exp_seq[k] || gnt0_v[0] !== !exp_seq[k]) begin
                errors++; $display("FAIL sat_cnt2 beat %0d got g0=%b g1=%b exp g1=%b",
                                   k, gnt0_v[0], gnt1_v[0], exp_seq[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        req0_v[0] = 1'b1; req1_v[0] = 1'b1; out_ready_v[0] = 1'b1;
        data0_v[0] = 24'h0C0C0C; data1_v[0] = 24'h0D0D0D;
        repeat (6) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid_v[0] !== 1'b1 || out_src_v[0] !== 1'b1) begin
            errors++; $display("FAIL midburst_pre got v=%b s=%b exp v=1 s=1",
                               out_valid_v[0], out_src_v[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid_v[0], out_data_v[0], gnt0_v[0], gnt1_v[0]} !== 27'h0) begin
            errors++; $display("FAIL midburst_reset got v=%b d=%h g0=%b g1=%b exp all 0",
                               out_valid_v[0], out_data_v[0], gnt0_v[0], gnt1_v[0]);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt0_v[0], gnt1_v[0]} !== 2'b10) begin
            errors++; $display("FAIL midburst_first got %b exp 10", {gnt0_v[0], gnt1_v[0]});
        end
        @(posedge clk); #1;
    endtask

    // Reference model state: output register contents, pending requester words and
    // the log of granted sources (newest first) that drives the burst rule.
    bit          m_valid[3];
    logic [23:0] m_data[3];
    bit          m_src[3];
    bit          hist[3][16];
    int          hist_n[3];
    bit          pend0[3];
    bit          pend1[3];
    logic [23:0] w0[3];
    logic [23:0] w1[3];

    function automatic void model_grant(input int i, output bit g0, output bit g1);
        bit lst;
        int run;
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_valid[i] && !out_ready_v[i]) return;
        if (pend0[i] && pend1[i]) begin
            lst = (hist_n[i] > 0) ? hist[i][0] : 1'b0;
            run = 0;
            while (run < hist_n[i] && hist[i][run] == lst) run++;
            g1 = (run < burst_of(i)) ? lst : !lst;
            g0 = !g1;
        end else begin
            g0 = pend0[i];
            g1 = pend1[i];
        end
    endfunction

    task automatic test_random();
        bit g0;
        bit g1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_src[i] = 1'b0;
            hist_n[i] = 0; pend0[i] = 1'b0; pend1[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend0[i] && $urandom_range(0, 99) < 60) begin
                    pend0[i] = 1'b1; w0[i] = 24'($urandom);
                end
                if (!pend1[i] && $urandom_range(0, 99) < 60) begin
                    pend1[i] = 1'b1; w1[i] = 24'($urandom);
                end
                req0_v[i] = pend0[i];
                req1_v[i] = pend1[i];
                data0_v[i] = pend0[i] ? w0[i] : 24'($urandom);
                data1_v[i] = pend1[i] ? w1[i] : 24'($urandom);
                out_ready_v[i] = ($urandom_range(0, 99) < 70);
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                model_grant(i, g0, g1);
                checks++;
                if ((gnt0_v[i] & gnt1_v[i]) !== 1'b0) begin
                    errors++; $display("FAIL rand_double inst %0d cyc %0d", i, cyc);
                end
                checks++;
                if (gnt0_v[i] !== g0 || gnt1_v[i] !== g1 || sel_v[i] !== g1) begin
                    errors++; $display("FAIL rand_gnt inst %0d cyc %0d got g0=%b g1=%b sel=%b exp g0=%b g1=%b",
                                       i, cyc, gnt0_v[i], gnt1_v[i], sel_v[i], g0, g1);
                end
                checks++;
                if (out_valid_v[i] !== m_valid[i]) begin
                    errors++; $display("FAIL rand_valid inst %0d cyc %0d got %b exp %b",
                                       i, cyc, out_valid_v[i], m_valid[i]);
                end
                if (m_valid[i]) begin
                    checks++;
                    if (out_data_v[i] !== m_data[i] || out_src_v[i] !== m_src[i]) begin
                        errors++; $display("FAIL rand_word inst %0d cyc %0d got d=%h s=%b exp d=%h s=%b",
                                           i, cyc, out_data_v[i], out_src_v[i], m_data[i], m_src[i]);
                    end
                end
                if (g0 || g1) begin
                    m_valid[i] = 1'b1;
                    m_data[i]  = g1 ? w1[i] : w0[i];
                    m_src[i]   = g1;
                    for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = g1;
                    if (hist_n[i] < 16) hist_n[i]++;
                    if (g1) pend1[i] = 1'b0; else pend0[i] = 1'b0;
                end else if (m_valid[i] && out_ready_v[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
            if (errors > 40) break;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_saturate();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
